// File: rtl/button_conditioner.sv
// Two-channel push-button conditioner: 2-flop sync, debounce FSM, press/release/long pulses, chord detect.
// Press/release accepted DEBOUNCE_CYCLES+1 edges after the pin moves; all outputs registered, no backpressure.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 12000,
  parameter int LONG_PRESS_CYCLES = 6000000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic button_a,
  input  logic button_b,
  output logic level_a,
  output logic level_b,
  output logic press_a,
  output logic press_b,
  output logic release_a,
  output logic release_b,
  output logic long_a,
  output logic long_b,
  output logic chord
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  logic [1:0] pin_raw;
  logic [1:0] level_v;
  logic [1:0] press_v;
  logic [1:0] release_v;
  logic [1:0] long_v;
  logic       both_q, both_d;
  logic       chord_q, chord_d;

  assign pin_raw = {button_b, button_a};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic          sync1_q, sync2_q, s;
    state_t        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          held;

    // Sync flops reset to the idle pin level so s starts out released.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q   <= ACTIVE_LOW;
        sync2_q   <= ACTIVE_LOW;
        state_q   <= RELEASED;
        cnt_q     <= '0;
        hold_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        sync1_q   <= pin_raw[c];
        sync2_q   <= sync1_q;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        hold_q    <= hold_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
      end
    end

    assign s    = sync2_q ^ ACTIVE_LOW;
    assign held = (state_q == PRESSED) || (state_q == RELEASE_CHK);

    // The hold counter keeps running through RELEASE_CHK; only a confirmed release clears it.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = (held && (hold_q != HOLD_MAX)) ? hold_q + HW'(1) : hold_q;
      case (state_q)
        RELEASED: begin
          if (s) begin
            if (SINGLE) begin
              state_d = PRESSED;
              hold_d  = '0;
            end else begin
              state_d = PRESS_CHK;
              cnt_d   = DW'(1);
            end
          end
        end
        PRESS_CHK: begin
          if (!s) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            hold_d  = '0;
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            if (SINGLE) begin
              state_d = RELEASED;
              hold_d  = '0;
            end else begin
              state_d = RELEASE_CHK;
              cnt_d   = DW'(1);
            end
          end
        end
        RELEASE_CHK: begin
          if (s) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = RELEASED;
            cnt_d   = '0;
            hold_d  = '0;
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
          hold_d  = '0;
        end
      endcase
    end

    always_comb begin
      level_d   = (state_d == PRESSED) || (state_d == RELEASE_CHK);
      press_d   = !held && level_d;
      release_d = held && !level_d;
      long_d    = held && (hold_q == HOLD_LAST);
    end

    assign level_v[c]   = level_q;
    assign press_v[c]   = press_q;
    assign release_v[c] = release_q;
    assign long_v[c]    = long_q;
  end

  always_comb begin
    both_d  = level_v[0] & level_v[1];
    chord_d = both_d & ~both_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      both_q  <= 1'b0;
      chord_q <= 1'b0;
    end else begin
      both_q  <= both_d;
      chord_q <= chord_d;
    end
  end

  assign level_a   = level_v[0];
  assign level_b   = level_v[1];
  assign press_a   = press_v[0];
  assign press_b   = press_v[1];
  assign release_a = release_v[0];
  assign release_b = release_v[1];
  assign long_a    = long_v[0];
  assign long_b    = long_v[1];
  assign chord     = chord_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random pin activity against a history-window model.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int LP = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button_a = 1'b1;
  logic button_b = 1'b1;
  logic level_a, level_b, press_a, press_b, release_a, release_b, long_a, long_b, chord;

  int vectors = 0;
  int miscompares = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_PRESS_CYCLES(LP),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .button_a(button_a), .button_b(button_b),
    .level_a(level_a), .level_b(level_b), .press_a(press_a), .press_b(press_b),
    .release_a(release_a), .release_b(release_b), .long_a(long_a), .long_b(long_b),
    .chord(chord)
  );

  always #5 clk = ~clk;

  wire [8:0] dut_vec = {level_a, level_b, press_a, press_b, release_a, release_b, long_a, long_b, chord};

  // Reference: a level flips once the last DB synchronised samples all disagree with it;
  // long fires exactly LP edges after the accepting edge if still held.
  bit       m_p1 [2];
  bit       m_p2 [2];
  bit       m_lvl [2];
  bit       m_hist [2][DB];
  int       m_pe [2];
  int       m_ecnt = 0;
  bit       m_and;
  logic [8:0] exp_vec = '0;

  always @(posedge clk or posedge rst) begin : model
    bit pins [2];
    bit oldl [2];
    bit pr [2];
    bit rl [2];
    bit lg [2];
    bit ch;
    bit s;
    bit all_diff;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_p1[c]  = 1'b1;
        m_p2[c]  = 1'b1;
        m_lvl[c] = 1'b0;
        m_pe[c]  = 0;
        for (int k = 0; k < DB; k++) m_hist[c][k] = 1'b0;
      end
      m_and   = 1'b0;
      exp_vec = '0;
    end else begin
      pins[0] = button_a;
      pins[1] = button_b;
      m_ecnt++;
      for (int c = 0; c < 2; c++) begin
        oldl[c] = m_lvl[c];
        s = ~m_p2[c];
        m_p2[c] = m_p1[c];
        m_p1[c] = pins[c];
        lg[c] = m_lvl[c] && ((m_ecnt - m_pe[c]) == LP);
        for (int k = DB - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[c][0] = s;
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++) if (m_hist[c][k] == m_lvl[c]) all_diff = 1'b0;
        pr[c] = 1'b0;
        rl[c] = 1'b0;
        if (all_diff) begin
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) begin
            pr[c]   = 1'b1;
            m_pe[c] = m_ecnt;
          end else begin
            rl[c] = 1'b1;
          end
        end
      end
      ch    = oldl[0] & oldl[1] & ~m_and;
      m_and = oldl[0] & oldl[1];
      exp_vec = {m_lvl[0], m_lvl[1], pr[0], pr[1], rl[0], rl[1], lg[0], lg[1], ch};
    end
  end

  task automatic settle();
    button_a = 1'b1;
    button_b = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset();
    button_a = 1'b1;
    button_b = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (dut_vec !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_hold got %b expected %b", dut_vec, 9'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== 9'd0) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d got %b expected %b", i, dut_vec, 9'd0);
      end
    end
  endtask

  task automatic test_clean_press();
    int lat_p = -1;
    int lat_r = -1;
    settle();
    button_a = 1'b0;
    for (int i = 0; i < 20 && lat_p < 0; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL clean_press_vec t=%0t got %b expected %b", $time, dut_vec, exp_vec);
      end
      if (press_a === 1'b1) lat_p = i;
    end
    vectors++;
    if (lat_p != DB + 1) begin
      miscompares++;
      $display("FAIL clean_press_latency got %0d expected %0d", lat_p, DB + 1);
    end
    vectors++;
    if (level_a !== 1'b1) begin
      miscompares++;
      $display("FAIL clean_level got %b expected 1", level_a);
    end
    button_a = 1'b1;
    for (int i = 0; i < 20 && lat_r < 0; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL clean_release_vec t=%0t got %b expected %b", $time, dut_vec, exp_vec);
      end
      if (release_a === 1'b1) lat_r = i;
    end
    vectors++;
    if (lat_r != DB + 1) begin
      miscompares++;
      $display("FAIL clean_release_latency got %0d expected %0d", lat_r, DB + 1);
    end
  endtask

  task automatic test_bounce();
    int npress = 0;
    int nrel = 0;
    int pcyc = -1;
    settle();
    for (int cyc = 0; cyc < 45; cyc++) begin
      button_a = (cyc < 30) ? ((cyc / 2) % 2 != 0) : 1'b0;
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL bounce_vec cyc=%0d got %b expected %b", cyc, dut_vec, exp_vec);
      end
      if (press_a === 1'b1) begin
        npress++;
        pcyc = cyc;
      end
      if (release_a === 1'b1) nrel++;
    end
    vectors++;
    if (npress != 1 || pcyc != 28 + DB + 1) begin
      miscompares++;
      $display("FAIL bounce_press got count %0d at %0d expected 1 at %0d", npress, pcyc, 28 + DB + 1);
    end
    vectors++;
    if (nrel != 0) begin
      miscompares++;
      $display("FAIL bounce_spurious_release got %0d expected 0", nrel);
    end
  endtask

  task automatic test_long_press();
    int p = -1;
    int nlong = 0;
    int lcyc = -1;
    int nrel = 0;
    settle();
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (cyc >= 40) button_b = 1'b1;
      else if (p >= 0 && cyc >= p + 10 && cyc < p + 13) button_b = 1'b1;
      else button_b = 1'b0;
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL long_vec cyc=%0d got %b expected %b", cyc, dut_vec, exp_vec);
      end
      if (press_b === 1'b1 && p < 0) p = cyc;
      if (long_b === 1'b1) begin
        nlong++;
        lcyc = cyc;
      end
      if (release_b === 1'b1 && cyc < 45) nrel++;
    end
    vectors++;
    if (p != DB + 1) begin
      miscompares++;
      $display("FAIL long_press_latency got %0d expected %0d", p, DB + 1);
    end
    vectors++;
    if (nlong != 1 || lcyc != p + LP) begin
      miscompares++;
      $display("FAIL long_pulse got count %0d at %0d expected 1 at %0d", nlong, lcyc, p + LP);
    end
    vectors++;
    if (nrel != 0) begin
      miscompares++;
      $display("FAIL long_glitch_release got %0d expected 0", nrel);
    end
  endtask

  task automatic test_long_release_coincide();
    int p = -1;
    int lcyc = -1;
    int rcyc = -1;
    settle();
    for (int cyc = 0; cyc < 40; cyc++) begin
      button_b = (p >= 0 && cyc >= p + LP - DB - 1) ? 1'b1 : 1'b0;
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL coincide_vec cyc=%0d got %b expected %b", cyc, dut_vec, exp_vec);
      end
      if (press_b === 1'b1 && p < 0) p = cyc;
      if (long_b === 1'b1) lcyc = cyc;
      if (release_b === 1'b1) rcyc = cyc;
    end
    vectors++;
    if (lcyc != p + LP || rcyc != p + LP) begin
      miscompares++;
      $display("FAIL coincide got long@%0d release@%0d expected both @%0d", lcyc, rcyc, p + LP);
    end
  endtask

  task automatic test_chord();
    int pa = -1;
    int pb = -1;
    int c1 = -1;
    int c2 = -1;
    int nch = 0;
    settle();
    for (int cyc = 0; cyc < 45; cyc++) begin
      button_a = (cyc >= 15 && cyc < 25) ? 1'b1 : 1'b0;
      button_b = (cyc >= 40) ? 1'b1 : 1'b0;
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL chord_vec cyc=%0d got %b expected %b", cyc, dut_vec, exp_vec);
      end
      if (press_a === 1'b1 && pa < 0) pa = cyc;
      if (press_b === 1'b1 && pb < 0) pb = cyc;
      if (chord === 1'b1) begin
        nch++;
        if (c1 < 0) c1 = cyc;
        else c2 = cyc;
      end
    end
    vectors++;
    if (pa != DB + 1 || pb != DB + 1) begin
      miscompares++;
      $display("FAIL chord_presses got a@%0d b@%0d expected both @%0d", pa, pb, DB + 1);
    end
    vectors++;
    if (nch != 2 || c1 != DB + 2 || c2 != 25 + DB + 2) begin
      miscompares++;
      $display("FAIL chord_pulses got %0d at %0d,%0d expected 2 at %0d,%0d", nch, c1, c2, DB + 2, 25 + DB + 2);
    end
  endtask

  task automatic test_reset_mid();
    int seen = -1;
    int lat = -1;
    int nrel = 0;
    settle();
    button_a = 1'b0;
    for (int i = 0; i < 20 && seen < 0; i++) begin
      @(negedge clk);
      if (press_a === 1'b1) seen = i;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (level_a !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_pre_level got %b expected 1", level_a);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (dut_vec !== 9'd0) begin
      miscompares++;
      $display("FAIL midreset_async got %b expected %b", dut_vec, 9'd0);
    end
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL midreset_hold got %b expected %b", dut_vec, exp_vec);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL midreset_vec i=%0d got %b expected %b", i, dut_vec, exp_vec);
      end
      if (release_a === 1'b1) nrel++;
      if (press_a === 1'b1) lat = i;
    end
    vectors++;
    if (lat != DB + 1 || nrel != 0) begin
      miscompares++;
      $display("FAIL midreset_repress got latency %0d releases %0d expected %0d and 0", lat, nrel, DB + 1);
    end
  endtask

  task automatic test_random();
    int run [2];
    bit pv [2];
    settle();
    run[0] = 0;
    run[1] = 0;
    pv[0]  = 1'b1;
    pv[1]  = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (run[c] == 0) begin
          pv[c]  = ~pv[c];
          run[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 7));
        end
        run[c]--;
      end
      button_a = pv[0];
      button_b = pv[1];
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL random_vec cyc=%0d got %b expected %b", cyc, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_long_release_coincide();
    test_chord();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
